uart_rx: RTL and testbench

//  8N1 UART receiver on a memory-mapped input register. Bit 15 of OUT is the
//    "empty/consumed" flag; a valid frame loads OUT = {8'h00, data} and drops it.
//  CPU reads OUT, then pulses CLEAR to mark the byte consumed (OUT = 16'h8000).

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_baud_ctr.sv | 30 +++
 rtl/uart_rx.sv | 107 ++++++++++
 tb/tb_uart_rx.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and timing constants for the UART receiver.
// Default timing: 25 MHz clock, 115200 baud.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    localparam logic [15:0] CLKS_PER_BIT = 16'd217;
    localparam logic [15:0] HALF_BIT     = 16'd108;
    localparam logic [15:0] RX_EMPTY     = 16'h8000;

endpackage

// File: rtl/uart_rx_baud_ctr.sv
// Baud position counter: wraps 0..CLKS_PER_BIT-1 and flags the
// mid-bit sample point and the last cycle of each bit.
module uart_baud_ctr
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_tick_mid,
    output logic o_tick_end
);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (i_restart) begin
            r_cnt <= 16'd0;
        end else if (i_enable) begin
            if (r_cnt == CLKS_PER_BIT - 16'd1) r_cnt <= 16'd0;
            else                               r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_tick_mid = (r_cnt == HALF_BIT);
    assign o_tick_end = (r_cnt == CLKS_PER_BIT - 16'd1);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver into a memory-mapped register.
// out[15] set means the buffer is empty/consumed.
module uart_rx
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        RX,
    output logic [15:0] out
);

    rx_state_e   r_state;
    rx_state_e   w_next;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_stop_ok;
    logic [15:0] r_out;
    logic        w_en;
    logic        w_restart;
    logic        w_commit;
    logic        w_mid;
    logic        w_end;

    uart_baud_ctr u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_enable   (w_en),
        .i_restart  (w_restart),
        .o_tick_mid (w_mid),
        .o_tick_end (w_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // The detection edge itself counts as position 1 of the start bit,
    // so the counter is enabled (not restarted) when RX is first seen low.
    always_comb begin
        w_next    = r_state;
        w_en      = 1'b0;
        w_restart = 1'b0;
        w_commit  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!RX) begin
                    w_next = START;
                    w_en   = 1'b1;
                end else begin
                    w_restart = 1'b1;
                end
            end
            START: begin
                w_en = 1'b1;
                if (w_mid && RX) begin
                    w_next    = IDLE;
                    w_restart = 1'b1;
                end else if (w_end) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                w_en = 1'b1;
                if (w_end && r_bit_cnt == 4'd7) w_next = STOP;
            end
            STOP: begin
                w_en = 1'b1;
                if (w_end) begin
                    w_next   = IDLE;
                    w_commit = r_stop_ok;
                end
            end
            default: begin
                w_next    = IDLE;
                w_restart = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'd0;
            r_stop_ok <= 1'b0;
        end else begin
            if (r_state == START)
                r_bit_cnt <= 4'd0;
            else if (r_state == DATA && w_end)
                r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_state == DATA && w_mid)
                r_shift <= {RX, r_shift[7:1]};
            if (r_state == STOP && w_mid)
                r_stop_ok <= RX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_out <= 16'h0000;
        else if (clear)    r_out <= RX_EMPTY;
        else if (w_commit) r_out <= {8'h00, r_shift};
    end

    assign out = r_out;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx.
// Frames are driven bit by bit with commit-edge timing checks.
module tb_uart_rx;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        RX;
    logic [15:0] out;

    int checks = 0;
    int errors = 0;

    uart_rx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .RX    (RX),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Start low is driven just after edge E0; checks land at E0+2169
    // and E0+2170. Only din[7:0] goes on the line.
    task automatic send_frame(input string       tag,
                              input logic [15:0] din,
                              input logic        stop,
                              input logic        clr,
                              input logic [15:0] exp_before,
                              input logic [15:0] exp_after);
        logic [7:0] d;
        d = din[7:0];
        @(posedge clk);
        #1 RX = 1'b0;
        repeat (217) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 RX = d[i];
            repeat (217) @(posedge clk);
        end
        #1 RX = stop;
        repeat (216) @(posedge clk);
        #2 check({tag, "_pre"}, out, exp_before);
        clear = clr;
        @(posedge clk);
        #2 check({tag, "_commit"}, out, exp_after);
        clear = 1'b0;
        RX    = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        RX    = 1'b1;
        #1 check("por", out, 16'h0000);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // idle line, no clear: stays at reset value
        for (int i = 0; i < 10; i++) begin
            repeat (100) @(posedge clk);
            #2 check("idle", out, 16'h0000);
        end

        // clear pulse
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("clear", out, 16'h8000);
        repeat (300) @(posedge clk);
        #2 check("clear_hold", out, 16'h8000);

        send_frame("a5", 16'h00A5, 1'b1, 1'b0, 16'h8000, 16'h00A5);
        repeat (500) @(posedge clk);
        #2 check("a5_hold", out, 16'h00A5);

        send_frame("3c", 16'h003C, 1'b1, 1'b0, 16'h00A5, 16'h003C);
        repeat (1830) @(posedge clk);
        send_frame("ff", 16'h12FF, 1'b1, 1'b0, 16'h003C, 16'h00FF);

        // back-to-back: next start bit begins right after the commit edge
        send_frame("b2b", 16'h0081, 1'b1, 1'b0, 16'h00FF, 16'h0081);

        // 50-cycle glitch
        @(posedge clk);
        #1 RX = 1'b0;
        repeat (50) @(posedge clk);
        #1 RX = 1'b1;
        repeat (500) @(posedge clk);
        #2 check("glitch", out, 16'h0081);
        send_frame("5a", 16'h005A, 1'b1, 1'b0, 16'h0081, 16'h005A);

        // framing error leaves out untouched
        send_frame("ferr", 16'h0011, 1'b0, 1'b0, 16'h005A, 16'h005A);
        repeat (300) @(posedge clk);
        #2 check("ferr_hold", out, 16'h005A);
        send_frame("after_ferr", 16'h0066, 1'b1, 1'b0, 16'h005A, 16'h0066);

        // clear wins over a same-edge commit
        send_frame("clr_win", 16'h0077, 1'b1, 1'b1, 16'h0066, 16'h8000);

        // async reset in the middle of a frame
        @(posedge clk);
        #1 RX = 1'b0;
        repeat (1000) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("rst_async", out, 16'h0000);
        RX = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2400) @(posedge clk);
        #2 check("rst_nocommit", out, 16'h0000);
        send_frame("c3", 16'h00C3, 1'b1, 1'b0, 16'h0000, 16'h00C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
